// File: rtl/pbch_symbol_extractor.sv
// Purpose: drops SSB symbol 0 and forwards symbols 1..3 in ascending-frequency order, with symbol/subcarrier indices.
// Latency: the upper half-band passes through in 1 cycle; the buffered lower half drains in the HALF cycles after bin FFT_LEN-1.
// Backpressure: none; input tvalid gaps freeze the input counters, while the drain engine keeps running every cycle.
module pbch_symbol_extractor #(
    parameter int IN_DW = 32,
    parameter int NFFT  = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    input  logic             SSB_start_i,
    output logic [IN_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    output logic             m_axis_out_tlast,
    output logic             PBCH_start_o,
    output logic [1:0]       sym_idx_o,
    output logic [NFFT-1:0]  sc_idx_o,
    output logic             ssb_done_o
);

    localparam int FFT_LEN = 2 ** NFFT;
    localparam int HALF    = FFT_LEN / 2;
    localparam int AW      = NFFT - 1;

    localparam logic [NFFT-1:0] BIN_LAST      = NFFT'(FFT_LEN - 1);
    localparam logic [NFFT-1:0] BIN_HALF      = NFFT'(HALF);
    localparam logic [NFFT-1:0] BIN_HALF_LAST = NFFT'(HALF - 1);
    localparam logic [AW-1:0]   ADDR_LAST     = AW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_FIRST_HALF,
        S_SECOND_HALF
    } state_t;

    state_t            state_q;
    logic [NFFT-1:0]   bin_q;
    logic [1:0]        sym_q;
    logic              bank_q;

    logic              drain_act_q;
    logic [AW-1:0]     drain_addr_q;
    logic              drain_bank_q;
    logic [1:0]        drain_sym_q;

    logic [IN_DW-1:0]  out_dat_q;
    logic              out_vld_q;
    logic              out_last_q;
    logic              out_done_q;
    logic [1:0]        out_sym_q;
    logic [NFFT-1:0]   out_sc_q;

    // Two banks of HALF samples each, addressed {bank, bin}; contents are never reset.
    logic [IN_DW-1:0]  buf_mem [0:FFT_LEN-1];

    logic              restart;
    logic              pass_acc;
    logic              wr_en;
    logic [NFFT-1:0]   bin_d;
    logic [IN_DW-1:0]  rd_dat;

    assign restart  = s_axis_in_tvalid && SSB_start_i && (state_q != S_IDLE);
    assign pass_acc = s_axis_in_tvalid && !restart && (state_q == S_SECOND_HALF);
    assign wr_en    = s_axis_in_tvalid && !restart && (state_q == S_FIRST_HALF);
    assign bin_d    = bin_q + NFFT'(1);
    assign rd_dat   = buf_mem[{drain_bank_q, drain_addr_q}];

    // The first sample in frequency order is bin HALF of symbol 1; flag it in the cycle it is
    // accepted so the consumer sees the pulse exactly one cycle ahead of the first valid output.
    assign PBCH_start_o = pass_acc && (sym_q == 2'd1) && (bin_q == BIN_HALF);

    assign m_axis_out_tdata  = out_dat_q;
    assign m_axis_out_tvalid = out_vld_q;
    assign m_axis_out_tlast  = out_last_q;
    assign sym_idx_o         = out_sym_q;
    assign sc_idx_o          = out_sc_q;
    assign ssb_done_o        = out_done_q;

    // Lower half-band of each forwarded symbol is parked in the active bank.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            buf_mem[{bank_q, bin_q[AW-1:0]}] <= s_axis_in_tdata;
        end
    end

    // Input FSM with bin/symbol counters, bank pointer and the drain engine it launches.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            sym_q        <= '0;
            bank_q       <= 1'b0;
            drain_act_q  <= 1'b0;
            drain_addr_q <= '0;
            drain_bank_q <= 1'b0;
            drain_sym_q  <= '0;
        end else begin
            // The drain runs one address per cycle, independent of input gaps.
            if (drain_act_q) begin
                drain_addr_q <= drain_addr_q + AW'(1);
                if (drain_addr_q == ADDR_LAST) begin
                    drain_act_q <= 1'b0;
                end
            end

            if (restart) begin
                // A new SSB mid-stream abandons everything buffered so far.
                state_q     <= S_SKIP;
                bin_q       <= NFFT'(1);
                sym_q       <= 2'd0;
                bank_q      <= 1'b0;
                drain_act_q <= 1'b0;
            end else if (s_axis_in_tvalid) begin
                case (state_q)
                    S_IDLE: begin
                        if (SSB_start_i) begin
                            state_q <= S_SKIP;
                            bin_q   <= NFFT'(1);
                            sym_q   <= 2'd0;
                        end
                    end
                    S_SKIP: begin
                        bin_q <= bin_d;
                        if (bin_q == BIN_LAST) begin
                            state_q <= S_FIRST_HALF;
                            sym_q   <= 2'd1;
                        end
                    end
                    S_FIRST_HALF: begin
                        bin_q <= bin_d;
                        if (bin_q == BIN_HALF_LAST) begin
                            state_q <= S_SECOND_HALF;
                        end
                    end
                    S_SECOND_HALF: begin
                        bin_q <= bin_d;
                        if (bin_q == BIN_LAST) begin
                            drain_act_q  <= 1'b1;
                            drain_addr_q <= '0;
                            drain_bank_q <= bank_q;
                            drain_sym_q  <= sym_q;
                            bank_q       <= ~bank_q;
                            sym_q        <= sym_q + 2'd1;
                            state_q      <= (sym_q < 2'd3) ? S_FIRST_HALF : S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Single output register: drain has priority over passthrough; restart silences both.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_done_q <= 1'b0;
            out_sym_q  <= '0;
            out_sc_q   <= '0;
        end else begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_done_q <= 1'b0;
            if (!restart) begin
                if (drain_act_q) begin
                    out_vld_q  <= 1'b1;
                    out_dat_q  <= rd_dat;
                    out_sym_q  <= drain_sym_q;
                    out_sc_q   <= {1'b1, drain_addr_q};
                    out_last_q <= (drain_addr_q == ADDR_LAST);
                    out_done_q <= (drain_addr_q == ADDR_LAST) && (drain_sym_q == 2'd3);
                end else if (pass_acc) begin
                    out_vld_q  <= 1'b1;
                    out_dat_q  <= s_axis_in_tdata;
                    out_sym_q  <= sym_q;
                    out_sc_q   <= {1'b0, bin_q[AW-1:0]};
                end
            end
        end
    end

    // The drain must always finish before the next symbol's upper half-band arrives.
    a_no_output_overlap: assert property (@(posedge clk_i) disable iff (reset_i)
        !(drain_act_q && pass_acc));

endmodule

// File: tb/tb_pbch_symbol_extractor.sv
// Purpose: self-checking bench for pbch_symbol_extractor using an expected-output queue.
// Latency: expectations are queued per symbol before driving; the monitor pops one per valid output.
// Backpressure: none; input gaps are generated at a configurable density.
module tb_pbch_symbol_extractor;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] in_dat;
    logic        in_vld;
    logic        in_ssb;
    logic [31:0] m_dat;
    logic        m_vld;
    logic        m_last;
    logic        pbch;
    logic [1:0]  sym_idx;
    logic [7:0]  sc_idx;
    logic        done;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  sym;
        logic [7:0]  sc;
        logic        last;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int out_cnt = 0;
    int acc_edge = -1;
    int out_edge = -1;
    int pass_end_edge = -1;
    int drain_edge = -1;
    int pbch_edge = -1;
    bit pbch_prev = 1'b0;

    pbch_symbol_extractor #(.IN_DW(32), .NFFT(8)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axis_in_tdata  (in_dat),
        .s_axis_in_tvalid (in_vld),
        .SSB_start_i      (in_ssb),
        .m_axis_out_tdata (m_dat),
        .m_axis_out_tvalid(m_vld),
        .m_axis_out_tlast (m_last),
        .PBCH_start_o     (pbch),
        .sym_idx_o        (sym_idx),
        .sc_idx_o         (sc_idx),
        .ssb_done_o       (done)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_n++;

    function automatic logic [31:0] mk(input int s, input int b);
        return {s[15:0], b[15:0]};
    endfunction

    // Output monitor: every valid output is checked against the head of the expectation queue.
    always @(negedge clk_i) begin
        exp_t e;
        exp_t a;
        if (m_vld) begin
            out_cnt++;
            tests++;
            a = '{dat: m_dat, sym: sym_idx, sc: sc_idx, last: m_last, done: done};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got dat=%h sym=%0d sc=%0d, none expected", m_dat, sym_idx, sc_idx);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL out_sample: got dat=%h sym=%0d sc=%0d last=%0b done=%0b, want dat=%h sym=%0d sc=%0d last=%0b done=%0b",
                             a.dat, a.sym, a.sc, a.last, a.done, e.dat, e.sym, e.sc, e.last, e.done);
                end
            end
            if (sym_idx == 2'd1 && sc_idx == 8'd0) begin
                out_edge = edge_n;
                tests++;
                if (!pbch_prev) begin
                    fails++;
                    $display("FAIL pbch_before_first: got pbch_prev=0, want 1");
                end
            end
            if (sym_idx == 2'd1 && sc_idx == 8'd127) pass_end_edge = edge_n;
            if (sym_idx == 2'd1 && sc_idx == 8'd128) drain_edge = edge_n;
        end else if (m_last || done) begin
            tests++;
            fails++;
            $display("FAIL flags_without_valid: got last=%0b done=%0b, want 0", m_last, done);
        end
        if (pbch_prev) begin
            tests++;
            if (!(m_vld && sym_idx == 2'd1 && sc_idx == 8'd0)) begin
                fails++;
                $display("FAIL pbch_followup: got vld=%0b sym=%0d sc=%0d after pulse, want vld=1 sym=1 sc=0", m_vld, sym_idx, sc_idx);
            end
        end
        if (pbch) pbch_edge = edge_n;
        pbch_prev = pbch;
    end

    task automatic push_sym(input int s, input int ndrain);
        for (int b = 128; b < 256; b++)
            exp_q.push_back('{dat: mk(s, b), sym: 2'(s), sc: 8'(b - 128), last: 1'b0, done: 1'b0});
        for (int a = 0; a < ndrain; a++)
            exp_q.push_back('{dat: mk(s, a), sym: 2'(s), sc: 8'(a + 128), last: (a == 127), done: (a == 127 && s == 3)});
    endtask

    task automatic push_ssb();
        for (int s = 1; s < 4; s++) push_sym(s, 128);
    endtask

    // Drives one SSB (symbols 0..3, bins 0..255), stopping before (stop_sym, stop_bin).
    task automatic drive_ssb(input int pct, input int stop_sym, input int stop_bin);
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 256; b++) begin
                if (s == stop_sym && b == stop_bin) begin
                    in_vld = 1'b0;
                    in_ssb = 1'b0;
                    return;
                end
                while ($urandom_range(99) >= pct) begin
                    in_vld = 1'b0;
                    in_ssb = 1'($urandom);
                    in_dat = $urandom;
                    @(posedge clk_i); #1;
                end
                if (s == 1 && b == 128) acc_edge = edge_n + 1;
                in_dat = mk(s, b);
                in_vld = 1'b1;
                in_ssb = (s == 0 && b == 0);
                @(posedge clk_i); #1;
            end
        end
        in_vld = 1'b0;
        in_ssb = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i); #1;
        end
        repeat (4) @(posedge clk_i);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d outputs still pending, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        in_vld = 1'b0;
        in_ssb = 1'b0;
        in_dat = '0;
        #2;
        tests++;
        if (m_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_vld: got %b, want 0", m_vld);
        end
        tests++;
        if ({m_dat, m_last, pbch, sym_idx, sc_idx, done} !== 45'd0) begin
            fails++;
            $display("FAIL reset_outputs: got dat=%h last=%b pbch=%b sym=%0d sc=%0d done=%b, want all 0",
                     m_dat, m_last, pbch, sym_idx, sc_idx, done);
        end
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        tests++;
        if ({m_vld, pbch, done} !== 3'b000) begin
            fails++;
            $display("FAIL post_reset_idle: got vld=%b pbch=%b done=%b, want 0", m_vld, pbch, done);
        end
    endtask

    task automatic test_single_ssb();
        int c0;
        c0 = out_cnt;
        push_ssb();
        drive_ssb(100, 4, 0);
        wait_empty("single");
        tests++;
        if (out_cnt - c0 != 768) begin
            fails++;
            $display("FAIL single_count: got %0d outputs, want 768", out_cnt - c0);
        end
    endtask

    task automatic test_latency();
        push_ssb();
        drive_ssb(100, 4, 0);
        wait_empty("latency");
        tests++;
        if (out_edge != acc_edge) begin
            fails++;
            $display("FAIL latency_pass: got output at edge %0d, want %0d", out_edge, acc_edge);
        end
        tests++;
        if (pbch_edge != acc_edge - 1) begin
            fails++;
            $display("FAIL latency_pbch: got pulse at edge %0d, want %0d", pbch_edge, acc_edge - 1);
        end
        tests++;
        if (drain_edge != pass_end_edge + 1) begin
            fails++;
            $display("FAIL latency_drain: got drain start at edge %0d, want %0d", drain_edge, pass_end_edge + 1);
        end
    endtask

    task automatic test_gaps();
        int c0;
        c0 = out_cnt;
        push_ssb();
        drive_ssb(50, 4, 0);
        wait_empty("gaps");
        tests++;
        if (out_cnt - c0 != 768) begin
            fails++;
            $display("FAIL gaps_count: got %0d outputs, want 768", out_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = out_cnt;
        push_ssb();
        drive_ssb(100, 4, 0);
        push_ssb();
        drive_ssb(100, 4, 0);
        wait_empty("b2b");
        tests++;
        if (out_cnt - c0 != 1536) begin
            fails++;
            $display("FAIL b2b_count: got %0d outputs, want 1536", out_cnt - c0);
        end
    endtask

    task automatic test_restart();
        int c0;
        c0 = out_cnt;
        // Restart lands on symbol 2 bin 100: symbol 1's drain has emitted addresses 0..99 by then.
        push_sym(1, 100);
        drive_ssb(100, 2, 100);
        push_ssb();
        drive_ssb(100, 4, 0);
        wait_empty("restart");
        tests++;
        if (out_cnt - c0 != 228 + 768) begin
            fails++;
            $display("FAIL restart_count: got %0d outputs, want %0d", out_cnt - c0, 228 + 768);
        end
    endtask

    task automatic test_reset_mid_drain();
        int c0;
        push_sym(1, 128);
        drive_ssb(100, 2, 50);
        tests++;
        if (m_vld !== 1'b1 || sc_idx < 8'd128) begin
            fails++;
            $display("FAIL pre_reset_drain: got vld=%b sc=%0d, want vld=1 sc>=128", m_vld, sc_idx);
        end
        #2 reset_i = 1'b1;
        exp_q.delete();
        #1;
        tests++;
        if ({m_dat, m_vld, m_last, pbch, sym_idx, sc_idx, done} !== 46'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got dat=%h vld=%b last=%b pbch=%b sym=%0d sc=%0d done=%b, want all 0",
                     m_dat, m_vld, m_last, pbch, sym_idx, sc_idx, done);
        end
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        c0 = out_cnt;
        in_vld = 1'b0;
        in_ssb = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_dat = $urandom;
            @(posedge clk_i); #1;
        end
        in_ssb = 1'b0;
        repeat (140) @(posedge clk_i);
        #1;
        tests++;
        if (out_cnt != c0) begin
            fails++;
            $display("FAIL start_without_valid: got %0d outputs, want 0", out_cnt - c0);
        end
        c0 = out_cnt;
        push_ssb();
        drive_ssb(70, 4, 0);
        wait_empty("post_reset");
        tests++;
        if (out_cnt - c0 != 768) begin
            fails++;
            $display("FAIL post_reset_count: got %0d outputs, want 768", out_cnt - c0);
        end
    endtask

    initial begin
        test_reset();
        test_single_ssb();
        test_latency();
        test_gaps();
        test_back_to_back();
        test_restart();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
